sipo_deser: RTL and testbench
=============================

SIPO_DESER -- requirements
Module: sipo_deser

Interface
REQ-001 SHALL have parameter WIDTH, default 4: data bits per word (2..32).
REQ-002 SHALL have parameter MSB_FIRST, default 1: 1 = first received bit lands in po[WIDTH-1]; 0 = first bit lands in po[0].
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port clr, input, 1 bit: synchronous discard of the partial word.
REQ-006 SHALL have port si, input, 1 bit: serial data bit.
REQ-007 SHALL have port si_valid, input, 1 bit: si holds a bit.
REQ-008 SHALL have port si_ready, output, 1 bit: block accepts si this cycle.
REQ-009 SHALL have port po, output, WIDTH bits: assembled word, registered, feeds the downstream parallel-load register.
REQ-010 SHALL have port po_valid, output, 1 bit: po holds an unconsumed word.
REQ-011 SHALL have port po_ready, input, 1 bit: consumer takes po this cycle.

Function
REQ-012 SHALL accept a bit when si_valid && si_ready at a rising clk edge; no other condition consumes si.
REQ-013 SHALL track accepted bits with a counter, 0..FRAME-1, where FRAME = WIDTH (WIDTH+1 with parity, REQ-027).
REQ-014 SHALL place bits into an internal shift register in the order set by MSB_FIRST.
REQ-015 SHALL transfer the full word to po, and set po_valid the cycle after the last frame bit is accepted (latency 1 clk), with the counter returning to 0.
REQ-016 SHALL clear po_valid on po_valid && po_ready unless a new word transfers the same edge, in which case po updates and po_valid stays 1 (zero-bubble).
REQ-017 SHALL hold po and po_valid stable while po_valid && !po_ready.
REQ-018 SHALL drive si_ready = !(counter == FRAME-1 && po_valid && !po_ready); bits before the last frame bit are always accepted.
REQ-019 SHALL, on clr, zero the counter and drop any bit presented that edge (clr wins over si_valid); po/po_valid unaffected.
REQ-020 SHALL never lose or duplicate a word: every completed frame appears exactly once on po.
REQ-021 SHALL wrap the counter from FRAME-1 to 0 only on transfer, never by overflow.

Reset
REQ-022 SHALL, while rst_n = 0, force counter = 0, shift register = 0, po = 0, po_valid = 0, par_err = 0, asynchronously.
REQ-023 SHALL, on reset mid-frame, discard the partial word; the first accepted bit after release starts a new frame.
REQ-024 SHALL drive si_ready = 1 from the first edge after reset release.

Configuration
REQ-025 SHALL use macro SIPO_DESER_PARITY_EN to compile parity checking in or out.
REQ-026 SHALL, without the macro, use FRAME = WIDTH, with no par_err port.
REQ-027 SHALL, with the macro, use FRAME = WIDTH+1: the final bit is an even-parity bit over the data bits and is not stored in po.
REQ-028 SHALL, with the macro, add output par_err (1 bit), registered with po: 1 when the XOR of data and parity bits is 1, valid only while po_valid.

Structure
REQ-029 SHALL place in shared package sipo_pkg: default WIDTH constant, counter-width function ($clog2(WIDTH+1)), and frame-length constant.
REQ-030 SHALL implement the frame counter as sub-module sipo_bit_cnt (inc, clr, wrap-at-terminal, terminal-count flag).
REQ-031 SHALL keep the datapath and handshake in sipo_deser, target 120-400 RTL lines.

Verification
REQ-032 SHALL cover: reset, then bits 1,0,1,1 on consecutive cycles with po_ready=1, MSB_FIRST=1 -> po=4'b1011, po_valid high exactly 1 cycle after the 4th bit.
REQ-033 SHALL cover: MSB_FIRST=0, bits 1,0,0,0 -> po=4'b0001.
REQ-034 SHALL cover: po_ready=0, two words 1100 then 0101 streamed -> po holds 1100, si_ready low on the 4th bit of word 2; po_ready=1 -> 0101 follows, no loss.
REQ-035 SHALL cover: clr asserted after 2 bits, then 1,1,1,1 -> po=4'b1111; reset asserted after 3 bits -> po_valid=0, po=0 immediately.
REQ-036 SHALL cover, with SIPO_DESER_PARITY_EN: data 1011 with parity 1 -> par_err=0; with parity 0 -> par_err=1.
REQ-037 SHALL cover: continuous stream with po_ready=1 every cycle -> back-to-back words, po_valid never drops between them.

Source files
------------

// File: rtl/sipo_pkg.sv
// sipo_pkg -- shared constants and helpers for the serial-in/parallel-out
// deserializer.
//   WIDTH_DEF   : default data bits per word
//   PARITY_BITS : 1 when SIPO_DESER_PARITY_EN is defined, else 0
//   FRAME_DEF   : frame length for the default width
//   cnt_w()     : bit-counter width for a given data width
//   frame_len() : frame length (data bits plus optional parity bit)
// Optional feature macro: SIPO_DESER_PARITY_EN.
package sipo_pkg;

  localparam int WIDTH_DEF = 4;

`ifdef SIPO_DESER_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

  localparam int FRAME_DEF = WIDTH_DEF + PARITY_BITS;

  // Wide enough to count 0..WIDTH, which covers a parity-extended frame.
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

  function automatic int frame_len(input int width);
    return width + PARITY_BITS;
  endfunction

endpackage

// File: rtl/sipo_bit_cnt.sv
// sipo_bit_cnt -- frame bit counter for sipo_deser.
// Counts accepted bits 0..TERM and wraps to 0 only when a bit is accepted
// at the terminal count.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   inc   : count one accepted bit
//   clr   : synchronous clear, wins over inc
//   tc    : counter is at TERM (the next accepted bit completes the frame)
module sipo_bit_cnt
  import sipo_pkg::*;
#(
  parameter int CNT_W = cnt_w(WIDTH_DEF),
  parameter int TERM  = FRAME_DEF - 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic tc
);

  logic [CNT_W-1:0] cnt;

  assign tc = (cnt == CNT_W'(TERM));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= tc ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sipo_deser.sv
// sipo_deser -- serial-in / parallel-out deserializer with valid/ready
// handshakes on both sides.
// Ports:
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset
//   clr      : synchronous discard of the partial word
//   si       : serial data bit
//   si_valid : si holds a bit
//   si_ready : block accepts si this cycle
//   po       : assembled word (registered)
//   po_valid : po holds an unconsumed word
//   po_ready : consumer takes po this cycle
//   par_err  : (SIPO_DESER_PARITY_EN only) even-parity error, registered with po
// Parameters: WIDTH (2..32), MSB_FIRST (1: first bit lands in po[WIDTH-1]).
// Optional feature macro: SIPO_DESER_PARITY_EN adds a trailing even-parity
// bit to each frame and the par_err output.
module sipo_deser
  import sipo_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             si,
  input  logic             si_valid,
  output logic             si_ready,
  output logic [WIDTH-1:0] po,
  output logic             po_valid,
  input  logic             po_ready
`ifdef SIPO_DESER_PARITY_EN
  ,
  output logic             par_err
`endif
);

  localparam int FRAME = frame_len(WIDTH);
  localparam int CNT_W = cnt_w(WIDTH);

  logic             last;
  logic             accept;
  logic             xfer;
  logic             sr_en;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_shift;
  logic [WIDTH-1:0] word;

  sipo_bit_cnt #(
    .CNT_W(CNT_W),
    .TERM (FRAME - 1)
  ) u_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (accept),
    .clr  (clr),
    .tc   (last)
  );

  // Only the frame-completing bit can be stalled, and only while the
  // previous word is still waiting for the consumer.
  assign si_ready = !(last && po_valid && !po_ready);
  assign accept   = si_valid && si_ready && !clr;
  assign xfer     = accept && last;

  assign sr_shift = MSB_FIRST ? {sr[WIDTH-2:0], si} : {si, sr[WIDTH-1:1]};

`ifdef SIPO_DESER_PARITY_EN
  // The final frame bit is parity: it is checked, never stored.
  assign sr_en = accept && !last;
  assign word  = sr;
`else
  // The final bit is data: the word includes the bit arriving this edge.
  assign sr_en = accept;
  assign word  = sr_shift;
`endif

  // Stage boundary: shift register and output word register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr       <= '0;
      po       <= '0;
      po_valid <= 1'b0;
`ifdef SIPO_DESER_PARITY_EN
      par_err  <= 1'b0;
`endif
    end else begin
      if (sr_en) begin
        sr <= sr_shift;
      end
      if (xfer) begin
        po       <= word;
        po_valid <= 1'b1;
`ifdef SIPO_DESER_PARITY_EN
        par_err  <= ^{sr, si};
`endif
      end else if (po_ready) begin
        po_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sipo_deser.sv
// tb_sipo_deser -- directed bench for sipo_deser. Two instances share all
// inputs: one MSB-first, one LSB-first. Builds with or without
// SIPO_DESER_PARITY_EN; frames carry a trailing even-parity bit when defined.
module tb_sipo_deser;

`ifdef SIPO_DESER_PARITY_EN
  localparam int FR = 5;
`else
  localparam int FR = 4;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr;
  logic       si;
  logic       si_valid;
  logic       po_ready;
  logic [3:0] po_m, po_l;
  logic       pv_m, pv_l;
  logic       sr_m, sr_l;
`ifdef SIPO_DESER_PARITY_EN
  logic       pe_m, pe_l;
`endif

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  sipo_deser #(.WIDTH(4), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .si(si), .si_valid(si_valid),
    .si_ready(sr_m), .po(po_m), .po_valid(pv_m), .po_ready(po_ready)
`ifdef SIPO_DESER_PARITY_EN
    , .par_err(pe_m)
`endif
  );

  sipo_deser #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .clr(clr), .si(si), .si_valid(si_valid),
    .si_ready(sr_l), .po(po_l), .po_valid(pv_l), .po_ready(po_ready)
`ifdef SIPO_DESER_PARITY_EN
    , .par_err(pe_l)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Frame bit i of word d, sent in written order d[3]..d[0], then parity.
  function automatic logic fbit(input logic [3:0] d, input int i);
    if (i < 4) return d[3-i];
    return ^d;
  endfunction

  task automatic send(input logic [3:0] d, input int first, input int last_i);
    for (int i = first; i <= last_i; i++) begin
      si       = fbit(d, i);
      si_valid = 1'b1;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle();
    si_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b0;
    clr      = 1'b0;
    si       = 1'b0;
    si_valid = 1'b0;
    po_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_po", po_m, 4'h0);
    check("rst_po_valid", pv_m, 1'b0);
    check("rst_si_ready", sr_m, 1'b1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_si_ready", sr_m, 1'b1);

    // Bits 1,0,1,1: word valid exactly one cycle after the last bit
    send(4'b1011, 0, FR-2);
    check("t1_mid_valid", pv_m, 1'b0);
    send(4'b1011, FR-1, FR-1);
    check("t1_valid", pv_m, 1'b1);
    check("t1_po_msb", po_m, 4'b1011);
    check("t1_po_lsb", po_l, 4'b1101);
    idle();
    check("t1_consumed", pv_m, 1'b0);
    check("t1_po_hold", po_m, 4'b1011);

    // Bits 1,0,0,0: LSB-first instance reports 0001
    send(4'b1000, 0, FR-1);
    check("t2_po_msb", po_m, 4'b1000);
    check("t2_po_lsb", po_l, 4'b0001);
    check("t2_valid_lsb", pv_l, 1'b1);
    idle();

    // Backpressure: second word stalls on its final bit, then zero-bubble
    po_ready = 1'b0;
    send(4'b1100, 0, FR-1);
    check("t3_w1_valid", pv_m, 1'b1);
    check("t3_w1_po", po_m, 4'b1100);
    send(4'b0101, 0, FR-2);
    si       = fbit(4'b0101, FR-1);
    si_valid = 1'b1;
    #1;
    check("t3_stall_ready", sr_m, 1'b0);
    @(posedge clk);
    #1;
    check("t3_hold_po", po_m, 4'b1100);
    check("t3_hold_valid", pv_m, 1'b1);
    check("t3_still_stalled", sr_l, 1'b0);
    po_ready = 1'b1;
    #1;
    check("t3_release_ready", sr_m, 1'b1);
    @(posedge clk);
    #1;
    check("t3_w2_po", po_m, 4'b0101);
    check("t3_w2_valid", pv_m, 1'b1);
    check("t3_w2_po_lsb", po_l, 4'b1010);
    idle();
    check("t3_drained", pv_m, 1'b0);

    // clr after two bits discards them and the bit presented with clr
    send(4'b1011, 0, 1);
    clr      = 1'b1;
    si       = 1'b1;
    si_valid = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    check("t4_clr_no_valid", pv_m, 1'b0);
    send(4'b1111, 0, FR-2);
    check("t4_mid_valid", pv_m, 1'b0);
    send(4'b1111, FR-1, FR-1);
    check("t4_po_msb", po_m, 4'b1111);
    check("t4_po_lsb", po_l, 4'b1111);
    check("t4_valid", pv_m, 1'b1);

    // Reset three bits into a frame clears outputs at once
    po_ready = 1'b0;
    send(4'b0110, 0, 2);
    check("t4_pre_rst_valid", pv_m, 1'b1);
    rst_n = 1'b0;
    #1;
    check("t4_rst_valid", pv_m, 1'b0);
    check("t4_rst_po", po_m, 4'h0);
    si_valid = 1'b0;
    @(negedge clk);
    rst_n    = 1'b1;
    po_ready = 1'b1;
    @(posedge clk);
    #1;
    send(4'b0011, 0, FR-2);
    check("t4_new_frame_mid", pv_m, 1'b0);
    send(4'b0011, FR-1, FR-1);
    check("t4_new_frame_po", po_m, 4'b0011);
    check("t4_new_frame_valid", pv_m, 1'b1);
    idle();

    // Continuous stream, consumer always ready
    send(4'b1010, 0, FR-1);
    check("t5_w1_po", po_m, 4'b1010);
    check("t5_w1_po_lsb", po_l, 4'b0101);
    check("t5_w1_valid", pv_m, 1'b1);
    send(4'b0110, 0, FR-1);
    check("t5_w2_po", po_m, 4'b0110);
    check("t5_w2_valid", pv_m, 1'b1);
    send(4'b1001, 0, FR-1);
    check("t5_w3_po", po_m, 4'b1001);
    check("t5_w3_valid", pv_m, 1'b1);
    check("t5_w3_po_lsb", po_l, 4'b1001);
    idle();

`ifdef SIPO_DESER_PARITY_EN
    // Data 1011 with correct parity 1, then with wrong parity 0
    send(4'b1011, 0, 3);
    si       = 1'b1;
    si_valid = 1'b1;
    @(posedge clk);
    #1;
    check("t6_good_po", po_m, 4'b1011);
    check("t6_good_par", pe_m, 1'b0);
    check("t6_good_par_lsb", pe_l, 1'b0);
    send(4'b1011, 0, 3);
    si       = 1'b0;
    si_valid = 1'b1;
    @(posedge clk);
    #1;
    check("t6_bad_po", po_m, 4'b1011);
    check("t6_bad_par", pe_m, 1'b1);
    check("t6_bad_valid", pv_m, 1'b1);
    idle();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
